note_sequencer: RTL and testbench

NOTE_SEQUENCER -- requirements
Module: note_sequencer

---
 rtl/note_sequencer_pkg.sv | 81 ++++++++
 rtl/note_sequencer_rom.sv | 46 ++++
 rtl/note_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_note_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/note_sequencer_pkg.sv
// Shared definitions for the note sequencer: controller states, song-table
// entry layout, the end-marker duration and the pitch encodings.
package note_sequencer_pkg;

  localparam int IDX_W     = 5;
  localparam int PITCH_W   = 4;
  localparam int OCT_W     = 2;
  localparam int DUR_W     = 3;
  localparam int ENTRY_W   = PITCH_W + OCT_W + DUR_W;

  // Bit offsets of each field inside a raw 9-bit table word
  localparam int DUR_LSB   = 0;
  localparam int OCT_LSB   = DUR_LSB + DUR_W;
  localparam int PITCH_LSB = OCT_LSB + OCT_W;

  // A duration of zero terminates the song
  localparam logic [DUR_W-1:0] END_MARKER = 3'd0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SYNC  = 3'd2,
    ST_PLAY  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // 0 is a rest, 1..7 are do..si, 8..15 are reserved
  typedef enum logic [PITCH_W-1:0] {
    P_REST = 4'd0,
    P_DO   = 4'd1,
    P_RE   = 4'd2,
    P_MI   = 4'd3,
    P_FA   = 4'd4,
    P_SOL  = 4'd5,
    P_LA   = 4'd6,
    P_SI   = 4'd7
  } pitch_t;

  // Octave code 1 is the "4" octave of the reference tune (C4, E4)
  localparam logic [OCT_W-1:0] OCT_4 = 2'd1;

  typedef struct packed {
    logic [PITCH_W-1:0] pitch;
    logic [OCT_W-1:0]   octave;
    logic [DUR_W-1:0]   duration;
  } entry_t;

  // Split a raw table word into its fields
  function automatic entry_t entry_from_bits(input logic [ENTRY_W-1:0] b);
    entry_t e;
    e.pitch    = b[PITCH_LSB +: PITCH_W];
    e.octave   = b[OCT_LSB +: OCT_W];
    e.duration = b[DUR_LSB +: DUR_W];
    return e;
  endfunction

  // Build a table entry from its fields
  function automatic entry_t make_entry(input logic [PITCH_W-1:0] p,
                                        input logic [OCT_W-1:0]   o,
                                        input logic [DUR_W-1:0]   d);
    entry_t e;
    e.pitch    = p;
    e.octave   = o;
    e.duration = d;
    return e;
  endfunction

  function automatic logic is_end(input entry_t e);
    return (e.duration == END_MARKER);
  endfunction

  // A one-beat note is too short for the divider and is stretched to two
  function automatic logic [DUR_W-1:0] beats_of(input logic [DUR_W-1:0] d);
    return (d == 3'd1) ? 3'd2 : d;
  endfunction

  function automatic logic is_note(input logic [PITCH_W-1:0] p);
    return (p >= P_DO) && (p <= P_SI);
  endfunction

endpackage

// File: rtl/note_sequencer_rom.sv
// Two-song table with a registered read port (one cycle of read latency).
// Song 0 is a short two-note tune; song 1 fills the whole table with
// playable entries so the sequencer runs to the last index.
module song_rom
  import note_sequencer_pkg::*;
#(
  parameter int SONG_LEN = 32
) (
  input  logic               i_clk,
  input  logic               i_song_sel,
  input  logic [IDX_W-1:0]   i_addr,
  output logic [ENTRY_W-1:0] o_entry
);

  logic [ENTRY_W-1:0] r_entry;

  // Table contents; addresses past the song length read as end markers
  function automatic entry_t rom_lookup(input logic sel, input logic [IDX_W-1:0] a);
    entry_t e;
    e = make_entry(P_REST, 2'd0, END_MARKER);
    if ({1'b0, a} >= 6'(SONG_LEN)) begin
      e = make_entry(P_REST, 2'd0, END_MARKER);
    end else if (!sel) begin
      case (a)
        5'd0:    e = make_entry(P_DO, OCT_4, 3'd2);
        5'd1:    e = make_entry(P_MI, OCT_4, 3'd3);
        default: e = make_entry(P_REST, 2'd0, END_MARKER);
      endcase
    end else begin
      case (a)
        5'd0:    e = make_entry(P_REST, 2'd0, 3'd2);
        5'd1:    e = make_entry(P_SOL, 2'd2, 3'd1);
        default: e = make_entry(4'(a % 5'd7) + 4'd1, a[1:0], 3'(a % 5'd3) + 3'd1);
      endcase
    end
    return e;
  endfunction

  // Registered read of the addressed entry
  always_ff @(posedge i_clk) begin
    r_entry <= rom_lookup(i_song_sel, i_addr);
  end

  assign o_entry = r_entry;

endmodule

// File: rtl/note_sequencer.sv
// Song playback controller: walks a song table one note per beat-phase
// wrap, presenting pitch/octave/duration to the tone and divider logic.
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int SONG_LEN = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_song_sel,
  input  logic [2:0]         i_division,
  output logic [DUR_W-1:0]   o_note_number,
  output logic               o_en,
  output logic [PITCH_W-1:0] o_pitch,
  output logic [OCT_W-1:0]   o_octave,
  output logic               o_note_valid,
  output logic               o_busy,
  output logic               o_done,
  output logic [IDX_W-1:0]   o_index
);

  localparam logic [IDX_W-1:0] LAST_IDX = 5'(SONG_LEN - 1);

  state_t               r_state;
  entry_t               r_next;
  logic                 r_song;
  logic                 r_rd_pend;
  logic [2:0]           r_div_q;
  logic [IDX_W-1:0]     r_index;
  logic [DUR_W-1:0]     r_note_number;
  logic                 r_en;
  logic [PITCH_W-1:0]   r_pitch;
  logic [OCT_W-1:0]     r_octave;
  logic                 r_note_valid;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_wrap;
  logic                 w_rom_sel;
  logic [IDX_W-1:0]     w_rom_addr;
  logic [ENTRY_W-1:0]   w_rom_data;
  entry_t               w_rom_entry;

  // A wrap is the beat phase returning to zero from a non-zero value
  assign w_wrap      = (i_division == 3'd0) && (r_div_q != 3'd0);
  assign w_rom_entry = entry_from_bits(w_rom_data);

  // Table address: entry 0 on start, otherwise the entry after the one being loaded
  always_comb begin
    w_rom_sel  = r_song;
    w_rom_addr = r_index;
    case (r_state)
      ST_IDLE: begin
        w_rom_sel  = i_song_sel;
        w_rom_addr = 5'd0;
      end
      ST_SYNC: begin
        w_rom_sel  = r_song;
        w_rom_addr = r_index + 5'd1;
      end
      ST_PLAY: begin
        w_rom_sel  = r_song;
        w_rom_addr = r_index + 5'd2;
      end
      default: begin
        w_rom_sel  = r_song;
        w_rom_addr = r_index;
      end
    endcase
  end

  song_rom #(
    .SONG_LEN (SONG_LEN)
  ) u_rom (
    .i_clk      (i_clk),
    .i_song_sel (w_rom_sel),
    .i_addr     (w_rom_addr),
    .o_entry    (w_rom_data)
  );

  // Playback state machine with registered note, status and handshake outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_next        <= make_entry(P_REST, 2'd0, END_MARKER);
      r_song        <= 1'b0;
      r_rd_pend     <= 1'b0;
      r_div_q       <= 3'd0;
      r_index       <= 5'd0;
      r_note_number <= 3'd0;
      r_en          <= 1'b0;
      r_pitch       <= 4'd0;
      r_octave      <= 2'd0;
      r_note_valid  <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_div_q   <= i_division;
      r_rd_pend <= 1'b0;
      r_done    <= 1'b0;
      // The entry requested last cycle lands in the look-ahead register now
      if (r_rd_pend) begin
        r_next <= w_rom_entry;
      end

      if ((r_state != ST_IDLE) && i_stop) begin
        // Abort wins over wrap and start; no completion pulse
        r_state       <= ST_IDLE;
        r_index       <= 5'd0;
        r_note_number <= 3'd0;
        r_en          <= 1'b0;
        r_pitch       <= 4'd0;
        r_octave      <= 2'd0;
        r_note_valid  <= 1'b0;
        r_busy        <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_start) begin
              r_song    <= i_song_sel;
              r_index   <= 5'd0;
              r_rd_pend <= 1'b1;
              r_busy    <= 1'b1;
              r_state   <= ST_FETCH;
            end
          end

          ST_FETCH: begin
            // Any wrap seen here is ignored; SYNC waits for the next one
            r_en    <= 1'b1;
            r_state <= ST_SYNC;
          end

          ST_SYNC: begin
            if (w_wrap) begin
              if (is_end(r_next)) begin
                r_state       <= ST_DONE;
                r_done        <= 1'b1;
                r_en          <= 1'b0;
                r_note_number <= 3'd0;
                r_pitch       <= 4'd0;
                r_octave      <= 2'd0;
                r_note_valid  <= 1'b0;
              end else begin
                r_note_number <= beats_of(r_next.duration);
                r_pitch       <= r_next.pitch;
                r_octave      <= r_next.octave;
                r_note_valid  <= is_note(r_next.pitch);
                r_rd_pend     <= 1'b1;
                r_state       <= ST_PLAY;
              end
            end
          end

          ST_PLAY: begin
            if (w_wrap) begin
              if (is_end(r_next) || (r_index == LAST_IDX)) begin
                r_state       <= ST_DONE;
                r_done        <= 1'b1;
                r_en          <= 1'b0;
                r_note_number <= 3'd0;
                r_pitch       <= 4'd0;
                r_octave      <= 2'd0;
                r_note_valid  <= 1'b0;
              end else begin
                r_index       <= r_index + 5'd1;
                r_note_number <= beats_of(r_next.duration);
                r_pitch       <= r_next.pitch;
                r_octave      <= r_next.octave;
                r_note_valid  <= is_note(r_next.pitch);
                r_rd_pend     <= 1'b1;
              end
            end
          end

          ST_DONE: begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end

          default: begin
            r_state       <= ST_IDLE;
            r_index       <= 5'd0;
            r_note_number <= 3'd0;
            r_en          <= 1'b0;
            r_pitch       <= 4'd0;
            r_octave      <= 2'd0;
            r_note_valid  <= 1'b0;
            r_busy        <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_note_number = r_note_number;
  assign o_en          = r_en;
  assign o_pitch       = r_pitch;
  assign o_octave      = r_octave;
  assign o_note_valid  = r_note_valid;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_index       = r_index;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: a vector table for the reference
// two-note song plus hand sequences for stop, long song, rest, early wrap
// and asynchronous reset.
module tb_note_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       song_sel;
  logic [2:0] division;
  logic [2:0] note_number;
  logic       en;
  logic [3:0] pitch;
  logic [1:0] octave;
  logic       note_valid;
  logic       busy;
  logic       done;
  logic [4:0] index;

  int n_pass;
  int n_total;

  typedef struct {
    logic       st;
    logic       sp;
    logic       sel;
    logic [2:0] dv;
    logic       busy;
    logic       en;
    logic       valid;
    logic       done;
    logic [3:0] pitch;
    logic [1:0] oct;
    logic [2:0] nn;
    logic [4:0] idx;
  } vec_t;

  vec_t tbl [11];

  note_sequencer #(.SONG_LEN(32)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_stop        (stop),
    .i_song_sel    (song_sel),
    .i_division    (division),
    .o_note_number (note_number),
    .o_en          (en),
    .o_pitch       (pitch),
    .o_octave      (octave),
    .o_note_valid  (note_valid),
    .o_busy        (busy),
    .o_done        (done),
    .o_index       (index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic st, input logic sp, input logic sel,
                              input logic [2:0] dv, input logic b, input logic e,
                              input logic v, input logic d, input logic [3:0] p,
                              input logic [1:0] o, input logic [2:0] nn,
                              input logic [4:0] ix);
    vec_t r;
    r.st = st; r.sp = sp; r.sel = sel; r.dv = dv;
    r.busy = b; r.en = e; r.valid = v; r.done = d;
    r.pitch = p; r.oct = o; r.nn = nn; r.idx = ix;
    return r;
  endfunction

  // {busy,en,valid,done,pitch,octave,note_number,index}
  function automatic logic [17:0] obs();
    return {busy, en, note_valid, done, pitch, octave, note_number, index};
  endfunction

  function automatic logic [17:0] pack(input logic b, input logic e, input logic v,
                                       input logic d, input logic [3:0] p,
                                       input logic [1:0] o, input logic [2:0] nn,
                                       input logic [4:0] ix);
    return {b, e, v, d, p, o, nn, ix};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One beat-phase wrap; the wrap edge is the last edge of the task
  task automatic do_wrap();
    division = 3'd1;
    cyc();
    division = 3'd0;
    cyc();
  endtask

  task automatic start_song(input logic sel);
    song_sel = sel;
    start    = 1'b1;
    cyc();
    start    = 1'b0;
    cyc();
  endtask

  initial begin
    logic saw_done;
    n_pass   = 0;
    n_total  = 0;
    rst      = 1'b1;
    start    = 1'b0;
    stop     = 1'b0;
    song_sel = 1'b0;
    division = 3'd0;

    // Song 0: C4 d2, E4 d3, end (octave code 1)
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 3'd0, 5'd0);
    tbl[1]  = mk(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 3'd0, 5'd0);
    tbl[2]  = mk(1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 3'd0, 5'd0);
    tbl[3]  = mk(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 2'd1, 3'd2, 5'd0);
    tbl[4]  = mk(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 2'd1, 3'd2, 5'd0);
    tbl[5]  = mk(1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 2'd1, 3'd2, 5'd0);
    tbl[6]  = mk(1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 2'd1, 3'd2, 5'd0);
    tbl[7]  = mk(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd3, 2'd1, 3'd3, 5'd1);
    tbl[8]  = mk(1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd3, 2'd1, 3'd3, 5'd1);
    tbl[9]  = mk(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 2'd0, 3'd0, 5'd1);
    tbl[10] = mk(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 3'd0, 5'd1);

    #12;
    check("reset_state", 32'(obs()), 32'(pack(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 3'd0, 5'd0)));
    rst = 1'b0;
    cyc();

    // Reference song, one vector per cycle
    for (int i = 0; i < 11; i++) begin
      start    = tbl[i].st;
      stop     = tbl[i].sp;
      song_sel = tbl[i].sel;
      division = tbl[i].dv;
      cyc();
      check($sformatf("song0_vec%0d", i), 32'(obs()),
            32'(pack(tbl[i].busy, tbl[i].en, tbl[i].valid, tbl[i].done,
                     tbl[i].pitch, tbl[i].oct, tbl[i].nn, tbl[i].idx)));
    end
    division = 3'd0;
    start    = 1'b0;

    // Stop during the second note: straight to idle, no done pulse afterwards
    start_song(1'b0);
    do_wrap();
    do_wrap();
    check("stop_pre_second_note", 32'(obs()), 32'(pack(1'b1, 1'b1, 1'b1, 1'b0, 4'd3, 2'd1, 3'd3, 5'd1)));
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check("stop_idle", 32'(obs()), 32'(pack(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 3'd0, 5'd0)));
    saw_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      do_wrap();
      if (done) saw_done = 1'b1;
    end
    check("stop_no_done", 32'({saw_done, busy}), 32'(2'b00));

    // Song 1: rest, short note, then every index through 31
    start_song(1'b1);
    do_wrap();
    check("rest_note", 32'(obs()), 32'(pack(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 3'd2, 5'd0)));
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("start_while_busy", 32'({busy, index}), 32'({1'b1, 5'd0}));
    do_wrap();
    check("dur1_as_2", 32'(obs()), 32'(pack(1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 2'd2, 3'd2, 5'd1)));
    for (int k = 2; k < 32; k++) begin
      do_wrap();
      check($sformatf("long_idx%0d", k), 32'({busy, done, note_valid, index}),
            32'({1'b1, 1'b0, 1'b1, 5'(k)}));
    end
    do_wrap();
    check("long_done", 32'({busy, done, en, note_valid, index}), 32'({4'b1100, 5'd31}));
    cyc();
    check("long_idle", 32'({busy, done}), 32'(2'b00));

    // Wrap during FETCH is ignored
    division = 3'd1;
    cyc();
    song_sel = 1'b0;
    start    = 1'b1;
    cyc();
    start    = 1'b0;
    division = 3'd0;
    cyc();
    check("fetch_wrap_ignored", 32'(obs()), 32'(pack(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 3'd0, 5'd0)));
    cyc();
    do_wrap();
    check("sync_after_fetch_wrap", 32'(obs()), 32'(pack(1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 2'd1, 3'd2, 5'd0)));

    // Asynchronous reset mid-note, then replay from entry 0
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", 32'(obs()), 32'(pack(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 3'd0, 5'd0)));
    cyc();
    rst = 1'b0;
    cyc();
    check("after_reset_idle", 32'({busy, done}), 32'(2'b00));
    start_song(1'b0);
    do_wrap();
    check("replay_first_note", 32'(obs()), 32'(pack(1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 2'd1, 3'd2, 5'd0)));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
